// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: widths, opcodes, sequencer states, boot image.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: CPU_WORD_W / CPU_OP_W / CPU_A_W width constants, opcode_t, state_t,
// default_word() returning the power-on program word for a memory address.
package cpu_pkg;

  localparam int CPU_WORD_W = 8;
  localparam int CPU_OP_W   = 3;
  localparam int CPU_A_W    = CPU_WORD_W - CPU_OP_W;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_BNE   = 3'b100,
    OP_IN    = 3'b101,
    OP_OUT   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_HALTED
  } state_t;

  // Boot program: read switches, accumulate into M[31], display the running
  // total, loop while the total is non-zero, otherwise halt.
  function automatic logic [CPU_WORD_W-1:0] default_word(input logic [CPU_A_W-1:0] a);
    logic [CPU_WORD_W-1:0] w;
    w = '0;
    case (a)
      5'd0: w = {OP_IN,    5'd0};
      5'd1: w = {OP_STORE, 5'd30};
      5'd2: w = {OP_LOAD,  5'd31};
      5'd3: w = {OP_ADD,   5'd30};
      5'd4: w = {OP_STORE, 5'd31};
      5'd5: w = {OP_OUT,   5'd0};
      5'd6: w = {OP_BNE,   5'd0};
      5'd7: w = {OP_HALT,  5'd0};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cpu_core_if.sv
// Front-panel bundle of the CPU: switch input and four seven-segment outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level-valued.
//
// master: drives sw, observes disp0..disp3 (board / bench side)
// slave : reads sw, drives disp0..disp3 (cpu_core side)
interface cpu_core_if;
  import cpu_pkg::*;

  logic [CPU_WORD_W-1:0] sw;
  logic [6:0]            disp0;
  logic [6:0]            disp1;
  logic [6:0]            disp2;
  logic [6:0]            disp3;

  modport master (output sw, input disp0, input disp1, input disp2, input disp3);
  modport slave  (input sw, output disp0, output disp1, output disp2, output disp3);

endinterface

// File: rtl/seg7_decoder.sv
// Hex nibble to active-high seven-segment pattern, bit6..bit0 = g f e d c b a.
// Latency: combinational.
// Backpressure: none.
//
// nib : 4-bit value to show
// seg : segment drive pattern
module seg7_decoder (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    case (nib)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Three-cycle accumulator CPU (fetch/decode/execute) with a 32-word unified memory and hex displays.
// Latency: 3 clocks per instruction; displays follow registers combinationally.
// Backpressure: none; switches are sampled only on the execute edge of IN.
//
// clock   : rising-edge clock
// n_reset : synchronous reset, 1 = reset (reloads the boot program)
// bus     : sw in, disp0/disp1 = OUTR low/high nibble, disp2/disp3 = PC low/high nibble
module cpu_core
  import cpu_pkg::*;
#(
  parameter int WORD_W = CPU_WORD_W,
  parameter int OP_W   = CPU_OP_W
) (
  input  logic        clock,
  input  logic        n_reset,
  cpu_core_if.slave   bus
);

  localparam int A_W   = WORD_W - OP_W;
  localparam int MEM_D = 2 ** A_W;

  state_t            state, state_nxt;
  logic [A_W-1:0]    pc;
  logic [A_W-1:0]    ar;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] ir;
  logic [WORD_W-1:0] outr;
  logic [WORD_W-1:0] mem [MEM_D];
  opcode_t           op;

  assign op = opcode_t'(ir[WORD_W-1 -: OP_W]);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:   state_nxt = ST_DECODE;
      ST_DECODE:  state_nxt = ST_EXECUTE;
      ST_EXECUTE: state_nxt = (op == OP_HALT) ? ST_HALTED : ST_FETCH;
      ST_HALTED:  state_nxt = ST_HALTED;
      default:    state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (n_reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      ar    <= '0;
      acc   <= '0;
      ir    <= '0;
      outr  <= '0;
      // Memory is a register file so that reset can restore the boot image;
      // this branch also suppresses any store that was in flight.
      for (int i = 0; i < MEM_D; i++) begin
        mem[i] <= default_word(CPU_A_W'(i));
      end
    end else begin
      state <= state_nxt;
      case (state)
        ST_FETCH: begin
          ir <= mem[pc];
          pc <= pc + 1'b1;
        end
        ST_DECODE: ar <= ir[A_W-1:0];
        ST_EXECUTE: begin
          case (op)
            OP_LOAD:  acc     <= mem[ar];
            OP_STORE: mem[ar] <= acc;
            OP_ADD:   acc     <= acc + mem[ar];
            OP_SUB:   acc     <= acc - mem[ar];
            // Taken branch overrides the increment done during fetch.
            OP_BNE:   if (acc != '0) pc <= ar;
            OP_IN:    acc     <= bus.sw;
            OP_OUT:   outr    <= acc;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  logic [3:0] out_lo, out_hi, pc_lo, pc_hi;
  assign out_lo = outr[3:0];
  assign out_hi = 4'(outr >> 4);
  assign pc_lo  = 4'(pc);
  assign pc_hi  = 4'(pc >> 4);

  seg7_decoder u_disp0 (.nib(out_lo), .seg(bus.disp0));
  seg7_decoder u_disp1 (.nib(out_hi), .seg(bus.disp1));
  seg7_decoder u_disp2 (.nib(pc_lo),  .seg(bus.disp2));
  seg7_decoder u_disp3 (.nib(pc_hi),  .seg(bus.disp3));

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: instruction-level reference model plus directed scenarios.
// Latency: model commits each instruction 3 edges after it starts.
// Backpressure: n/a.
module tb_cpu_core;

  logic clock = 1'b0;
  logic n_reset;

  cpu_core_if bus ();

  cpu_core dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // opcode_addr encodings of the boot program
  localparam logic [7:0] PROG [8] = '{
    8'b101_00000, 8'b001_11110, 8'b000_11111, 8'b010_11110,
    8'b001_11111, 8'b110_00000, 8'b100_00000, 8'b111_00000
  };

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: architectural state plus the instruction in flight.
  logic [7:0] mmem [32];
  logic [4:0] mpc;
  logic [7:0] macc;
  logic [7:0] moutr;
  logic [7:0] cur;
  int         age;
  bit         halted;
  bit         mvalid = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
    end
  endtask

  task automatic execute(input logic [7:0] instr, input logic [7:0] swv);
    logic [4:0] a;
    a = instr[4:0];
    case (instr[7:5])
      3'd0: macc = mmem[a];
      3'd1: mmem[a] = macc;
      3'd2: macc = macc + mmem[a];
      3'd3: macc = macc - mmem[a];
      3'd4: if (macc != 8'd0) mpc = a;
      3'd5: macc = swv;
      3'd6: moutr = macc;
      default: halted = 1'b1;
    endcase
  endtask

  task automatic model_edge(input logic rst, input logic [7:0] swv);
    if (rst) begin
      for (int i = 0; i < 32; i++) mmem[i] = (i < 8) ? PROG[i] : 8'h00;
      mpc    = 5'd0;
      macc   = 8'd0;
      moutr  = 8'd0;
      age    = 0;
      halted = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid && !halted) begin
      age++;
      if (age == 1) begin
        cur = mmem[mpc];
        mpc = mpc + 5'd1;
      end
      if (age == 3) begin
        execute(cur, swv);
        age = 0;
      end
    end
  endtask

  // Compare process: advance the model on each rising edge, check displays on the falling edge.
  initial begin
    forever begin
      @(posedge clock);
      model_edge(n_reset, bus.sw);
      @(negedge clock);
      if (mvalid) begin
        check("disp0", {1'b0, bus.disp0}, {1'b0, SEG[moutr[3:0]]});
        check("disp1", {1'b0, bus.disp1}, {1'b0, SEG[moutr[7:4]]});
        check("disp2", {1'b0, bus.disp2}, {1'b0, SEG[mpc[3:0]]});
        check("disp3", {1'b0, bus.disp3}, {1'b0, SEG[{3'b000, mpc[4]}]});
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input logic [7:0] swv);
    n_reset = 1'b1;
    bus.sw  = swv;
    run(1);
    n_reset = 1'b0;
  endtask

  initial begin
    n_reset = 1'b1;
    bus.sw  = 8'd2;
    run(2);
    n_reset = 1'b0;

    check("rst_disp0", {1'b0, bus.disp0}, 8'b0011_1111);
    check("rst_disp1", {1'b0, bus.disp1}, 8'b0011_1111);
    check("rst_disp2", {1'b0, bus.disp2}, 8'b0011_1111);
    check("rst_disp3", {1'b0, bus.disp3}, 8'b0011_1111);

    // First loop: total 2
    run(18);
    check("loop1_disp0", {1'b0, bus.disp0}, 8'b0101_1011);
    check("loop1_disp1", {1'b0, bus.disp1}, 8'b0011_1111);
    check("model_outr2", moutr, 8'd2);

    // Taken BNE returns PC to 0
    run(3);
    check("bne_pc0", {1'b0, bus.disp2}, 8'b0011_1111);

    // Second loop: total 4, PC sits at 6 after OUT
    run(18);
    check("loop2_disp0", {1'b0, bus.disp0}, 8'b0110_0110);
    check("loop2_pc6", {1'b0, bus.disp2}, 8'b0111_1101);

    // Switch change between loops: 4 + 3 = 7
    bus.sw = 8'd3;
    run(21);
    check("loop3_disp0", {1'b0, bus.disp0}, 8'b0000_0111);
    check("model_outr7", moutr, 8'd7);

    // Reset landing on the execute edge of STORE 31 in the second loop
    do_reset(8'd5);
    run(35);
    check("pre_abort_outr5", {1'b0, bus.disp0}, 8'b0110_1101);
    n_reset = 1'b1;
    run(1);
    n_reset = 1'b0;
    check("abort_pc0", {1'b0, bus.disp2}, 8'b0011_1111);
    check("abort_outr0", {1'b0, bus.disp0}, 8'b0011_1111);
    run(18);
    check("after_abort_outr5", {1'b0, bus.disp0}, 8'b0110_1101);
    check("after_abort_hi0", {1'b0, bus.disp1}, 8'b0011_1111);

    // 128 + 128 wraps to 0: BNE falls through to HALT
    do_reset(8'd128);
    run(18);
    check("wrap_loop1_hi8", {1'b0, bus.disp1}, 8'b0111_1111);
    check("wrap_loop1_lo0", {1'b0, bus.disp0}, 8'b0011_1111);
    run(27);
    bus.sw = 8'd77;
    run(20);
    check("halt_pc8", {1'b0, bus.disp2}, 8'b0111_1111);
    check("halt_pc_hi0", {1'b0, bus.disp3}, 8'b0011_1111);
    check("halt_outr_lo", {1'b0, bus.disp0}, 8'b0011_1111);
    check("halt_outr_hi", {1'b0, bus.disp1}, 8'b0011_1111);
    check("model_halted", {7'd0, halted}, 8'd1);

    // Reset wins over HALTED
    do_reset(8'd9);
    check("unhalt_pc0", {1'b0, bus.disp2}, 8'b0011_1111);
    run(4);
    check("unhalt_pc2", {1'b0, bus.disp2}, 8'b0101_1011);

    // Each hex digit through IN/OUT
    for (int d = 0; d < 16; d++) begin
      do_reset(8'(d));
      run(18);
      check("hex_digit", {1'b0, bus.disp0}, {1'b0, SEG[d]});
    end

    // Randomized run with occasional resets; the compare process checks every cycle.
    do_reset(8'($urandom));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.sw = 8'd0;
          1: bus.sw = 8'd128;
          default: bus.sw = 8'($urandom);
        endcase
      end
      n_reset = ($urandom_range(0, 99) == 0);
      run(1);
    end
    n_reset = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter WORD_W, default 8: data/instruction word width.
REQ-002 Parameter OP_W, default 3: opcode field width; address width A_W = WORD_W-OP_W (5), memory depth 2**A_W (32 words).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 n_reset  input  1  reset, synchronous, active-high (1 = reset).
REQ-005 sw  input  8  switch input, read by IN.
REQ-006 disp0  output  7  seven-segment, low nibble of output register.
REQ-007 disp1  output  7  seven-segment, high nibble of output register.
REQ-008 disp2  output  7  seven-segment, low nibble of PC.
REQ-009 disp3  output  7  seven-segment, high nibble of PC (zero-extended).

Function
REQ-010 Accumulator machine with registers ACC, PC (A_W bits), IR (WORD_W bits), OUTR (WORD_W bits), and a 32x8 unified memory.
REQ-011 Instruction format: IR[7:5] opcode, IR[4:0] address.
REQ-012 Opcodes: 000 LOAD (ACC<=M[a]); 001 STORE (M[a]<=ACC); 010 ADD (ACC<=ACC+M[a]); 011 SUB (ACC<=ACC-M[a]); 100 BNE (if ACC!=0, PC<=a); 101 IN (ACC<=sw); 110 OUT (OUTR<=ACC); 111 HALT.
REQ-013 Arithmetic is modulo 2**WORD_W, no carry/overflow flags; BNE tests ACC value at the execute edge.
REQ-014 Sequencer states FETCH -> DECODE -> EXECUTE -> FETCH; HALT in EXECUTE moves to HALTED, which holds all registers until reset.
REQ-015 FETCH: IR<=M[PC], PC<=PC+1 (wraps 31->0). DECODE: operand address latched. EXECUTE: operation of REQ-012 committed.
REQ-016 Every non-HALT instruction takes exactly 3 cycles; a taken BNE overrides the incremented PC.
REQ-017 sw is sampled at the EXECUTE edge of IN; changes at other times have no effect.
REQ-018 Segment encoding active-high, bit6..bit0 = g f e d c b a; 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-019 Displays are combinational decodes of registered values.

Reset
REQ-020 While n_reset=1 at a clock edge: PC=0, ACC=0, IR=0, OUTR=0, state=FETCH, memory reloaded from the default program.
REQ-021 Reset mid-instruction aborts it with no memory write; reset dominates HALTED.
REQ-022 Default program: 0 IN; 1 STORE 30; 2 LOAD 31; 3 ADD 30; 4 STORE 31; 5 OUT; 6 BNE 0; 7 HALT; all other words 0.
REQ-023 Post-reset displays: disp0..disp3 all 0111111.

Structure
REQ-024 Shared package cpu_pkg holds the opcode enum, state enum, default-program constant and width constants.
REQ-025 One sub-module, seg7_decoder (4-bit in, 7-bit out), instantiated four times; datapath and sequencer stay in cpu_core.

Verification
REQ-026 Reset, sw=2, run 18 cycles -> OUTR=2, disp0=1011011, disp1=0111111.
REQ-027 sw=2 held, after further 21 cycles -> OUTR=4 (disp0=1100110); PC wraps back to 0 after BNE.
REQ-028 sw changed 2->3 mid-loop before IN -> next OUT equals previous total +3 (e.g. 4->7).
REQ-029 sw=128: loop 1 OUT=128, loop 2 sum wraps to 0, BNE not taken, HALT reached; PC/OUTR frozen thereafter (OUTR=0, PC=8).
REQ-030 Assert n_reset during EXECUTE of STORE 31 -> M[31] unchanged, next cycle PC=0, ACC=0, state FETCH.
REQ-031 Each hex digit 0-F forced into OUTR via IN/OUT -> disp0 matches REQ-018 table.
